// File: rtl/mult_seq_16_pkg.sv
// Shared constants and state encoding for the 16x16 sequential multiplier.
package mult_seq_16_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_CNT_W = 5;

  // Encoding 2'd3 is unused; the FSM decodes it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_seq_16_if.sv
// Start/busy/done handshake plus operands and result between pipeline control and the multiplier.
interface mult_seq_16_if;
  import mult_seq_16_pkg::*;

  logic                      start;
  logic [MULT_WIDTH-1:0]     A;
  logic [MULT_WIDTH-1:0]     B;
  logic                      busy;
  logic                      done;
  logic [2*MULT_WIDTH-1:0]   product;

  modport master (output start, A, B, input busy, done, product);
  modport slave  (input start, A, B, output busy, done, product);

endinterface

// File: rtl/mult_seq_16_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate.
module cla_16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  cb;

  // Bit and group generate/propagate, group carries, then in-group carries.
  always_comb begin
    g  = A & B;
    p  = A ^ B;
    c  = '0;
    gg = '0;
    gp = '0;
    cb = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    cb[0] = Cin;
    cb[1] = gg[0] | (gp[0] & Cin);
    cb[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    cb[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & Cin);
    cb[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cb[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[16] = cb[4];
  end

  assign S    = p ^ c[15:0];
  assign Cout = c[16];

endmodule

// File: rtl/mult_seq_16.sv
// Iterative 16x16 unsigned shift-add multiplier: one add-and-shift step per RUN cycle.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the unconsumed multiplier
// bits are all zero by barrel-shifting the remaining distance in one cycle.
module mult_seq_16
  import mult_seq_16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mult_seq_16_if.slave  bus
);

  mult_state_t            state_q, state_d;
  logic [MULT_WIDTH-1:0]  mcand_q, mcand_d;
  logic [MULT_WIDTH-1:0]  hi_q, hi_d;
  logic [MULT_WIDTH-1:0]  lo_q, lo_d;
  logic [MULT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*MULT_WIDTH-1:0] product_q, product_d;

  logic [MULT_WIDTH-1:0]  sum;
  logic                   sum_cout;
  logic                   exit_now;

  cla_16 u_cla (
    .A    (hi_q),
    .B    (mcand_q),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (sum_cout)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic [MULT_WIDTH-1:0] rem_mask;
  // Mask of the multiplier bits still waiting in lo (cnt of them, 1..16).
  assign rem_mask = 16'((17'd1 << cnt_q) - 17'd1);
  assign exit_now = ((lo_q & rem_mask) == '0);
`else
  assign exit_now = 1'b0;
`endif

  // State, operand and product registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath: accept in IDLE, add-and-shift in RUN, one-cycle DONE.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d = bus.A;
          hi_d    = '0;
          lo_d    = bus.B;
          cnt_d   = MULT_CNT_W'(MULT_WIDTH);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (exit_now) begin
          // Remaining multiplier bits are zero: skip the adds, just align the product.
          {hi_d, lo_d} = {hi_q, lo_q} >> cnt_q;
          cnt_d        = '0;
          state_d      = ST_DONE;
          product_d    = {hi_d, lo_d};
        end else begin
          // Carry-out of the add becomes the new MSB after the right shift.
          if (lo_q[0]) begin
            {hi_d, lo_d} = {sum_cout, sum, lo_q[MULT_WIDTH-1:1]};
          end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[MULT_WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) begin
            state_d   = ST_DONE;
            product_d = {hi_d, lo_d};
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult_seq_16.sv
// Self-checking bench for mult_seq_16: cycle-by-cycle compare against a behavioural model,
// plus directed vectors with hand-computed products and done cycles.
module tb_mult_seq_16;

  logic clk = 1'b0;
  logic rst;

  mult_seq_16_if bus ();

  mult_seq_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit stop   = 1'b0;

  // Behavioural model: an accepted start books a fixed number of busy cycles, then one done cycle.
  int          m_run_left;
  logic        m_done;
  logic [31:0] m_prod;
  logic [31:0] m_next;

  function automatic int run_cycles(logic [15:0] b);
    int msb;
    msb = -1;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
`ifdef MULT_EARLY_EXIT_EN
    if (b == 16'h0) return 1;
    if (msb == 15) return 16;
    return msb + 2;
`else
    return 16;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run_left <= 0;
      m_done     <= 1'b0;
      m_prod     <= '0;
      m_next     <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_run_left > 0) begin
      m_run_left <= m_run_left - 1;
      if (m_run_left == 1) begin
        m_done <= 1'b1;
        m_prod <= m_next;
      end
    end else if (bus.start) begin
      m_run_left <= run_cycles(bus.B);
      m_next     <= 32'(bus.A) * 32'(bus.B);
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle_compare();
    chk("busy", 32'(bus.busy), 32'(m_run_left > 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("product", bus.product, m_prod);
  endtask

  // Directed op from IDLE: checks the cycle done first rises and the product against literals.
  task automatic op(string name, logic [15:0] a, logic [15:0] b,
                    logic [31:0] exp_prod, int exp_cycle);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_cycle"}, 32'(k), 32'(exp_cycle));
    chk({name, "_product"}, bus.product, exp_prod);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", bus.product, 32'd0);
    rst = 1'b0;

    fork
      begin
        while (!stop) begin
          @(negedge clk);
          if (!rst && !stop) cycle_compare();
        end
      end
      begin
`ifdef MULT_EARLY_EXIT_EN
        op("basic", 16'h0003, 16'h0005, 32'h0000000F, 5);
`else
        op("basic", 16'h0003, 16'h0005, 32'h0000000F, 17);
`endif
        // Abort in cycle 4 of a run; outputs clear immediately, no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h0003;
        bus.B     = 16'h0005;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
        chk("midrun_rst_done", 32'(bus.done), 32'd0);
        chk("midrun_rst_product", bus.product, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);

        // Start held through RUN with operands changing mid-run: only the IDLE samples count.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h0007;
        bus.B     = 16'h0009;
        repeat (5) @(negedge clk);
        bus.A     = 16'h00FF;
        bus.B     = 16'hF0F0;
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

`ifdef MULT_EARLY_EXIT_EN
        op("ee_b0000", 16'h1234, 16'h0000, 32'h00000000, 2);
        op("ee_b0001", 16'h1234, 16'h0001, 32'h00001234, 3);
        op("ee_b0100", 16'h1234, 16'h0100, 32'h00123400, 11);
        op("ee_b8000", 16'h1234, 16'h8000, 32'h091A0000, 17);
`else
        op("ee_b0000", 16'h1234, 16'h0000, 32'h00000000, 17);
        op("ee_b0001", 16'h1234, 16'h0001, 32'h00001234, 17);
        op("ee_b0100", 16'h1234, 16'h0100, 32'h00123400, 17);
        op("ee_b8000", 16'h1234, 16'h8000, 32'h091A0000, 17);
`endif

        // Random traffic: start asserted at random, including while busy; B has varied widths.
        repeat (30000) begin
          @(negedge clk);
          bus.start = ($urandom_range(0, 3) == 0);
          bus.A     = 16'($urandom);
          bus.B     = 16'(16'($urandom) >> $urandom_range(0, 16));
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        stop = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
